// File: rtl/fb_writer_if.sv
// Command-side and SDRAM-side bundles for the framebuffer fill engine.
// The master of each bundle drives the request, the slave drives ready/ack.
interface fb_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_x;
  logic [13:0] cmd_y;
  logic [13:0] cmd_w;
  logic [13:0] cmd_h;
  logic [15:0] cmd_color;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );
endinterface

interface fb_mem_if;
  logic        fb_wen;
  logic [31:0] fb_addr;
  logic [31:0] fb_data;
  logic [3:0]  fb_mask;
  logic        ram_ack;

  modport master (
    output fb_wen, fb_addr, fb_data, fb_mask,
    input  ram_ack
  );

  modport slave (
    input  fb_wen, fb_addr, fb_data, fb_mask,
    output ram_ack
  );
endinterface

// File: rtl/fb_writer.sv
// Rectangle fill into the RGB565 framebuffer as masked 32-bit word writes; fb_wen rises 2 cycles after accept.
// One write outstanding, held until ram_ack and released before the next; cmd_ready low while busy. FB_WRITER_CLIP_EN clips to the visible area.
module fb_writer #(
  parameter logic [13:0] MAX_WIDTH   = 14'd800,
  parameter logic [13:0] MAX_HEIGHT  = 14'd480,
  parameter logic [13:0] ADDRESS_DIF = MAX_WIDTH / 14'd2
) (
  input  logic     sdram_clk,
  input  logic     reset,
  fb_cmd_if.slave  cmd,
  fb_mem_if.master mem,
  output logic     busy,
  output logic     fill_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [13:0] x;
    logic [13:0] y;
    logic [13:0] w;
    logic [13:0] h;
    logic [15:0] color;
  } fill_cmd_t;

  state_t      state_q, state_d;
  fill_cmd_t   cmd_q, cmd_d, cmd_in;
  logic [13:0] line_q, line_d;
  logic [14:0] wi_q, wi_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic [15:0] x_last;
  logic [14:0] wi_first, wi_last, wi_next;
  logic [14:0] cur_y;
  logic [31:0] line_base;
  logic        line_more;

  // Byte enables for word wi given the inclusive pixel span [x, xl].
  function automatic logic [3:0] word_mask(input logic [14:0] wi,
                                           input logic [13:0] x,
                                           input logic [15:0] xl);
    logic [15:0] even_col;
    logic [15:0] odd_col;
    logic        even_in;
    logic        odd_in;
    even_col = {wi, 1'b0};
    odd_col  = {wi, 1'b1};
    even_in  = (even_col >= {2'b00, x}) && (even_col <= xl);
    odd_in   = (odd_col  >= {2'b00, x}) && (odd_col  <= xl);
    return {even_in, even_in, odd_in, odd_in};
  endfunction

  always_comb begin
    cmd_in.x     = cmd.cmd_x;
    cmd_in.y     = cmd.cmd_y;
    cmd_in.w     = cmd.cmd_w;
    cmd_in.h     = cmd.cmd_h;
    cmd_in.color = cmd.cmd_color;
`ifdef FB_WRITER_CLIP_EN
    if (cmd.cmd_x >= MAX_WIDTH) begin
      cmd_in.w = '0;
    end else if (cmd.cmd_w > MAX_WIDTH - cmd.cmd_x) begin
      cmd_in.w = MAX_WIDTH - cmd.cmd_x;
    end
    if (cmd.cmd_y >= MAX_HEIGHT) begin
      cmd_in.h = '0;
    end else if (cmd.cmd_h > MAX_HEIGHT - cmd.cmd_y) begin
      cmd_in.h = MAX_HEIGHT - cmd.cmd_y;
    end
`endif
  end

  // Without clipping, the span may run past the line end; word indices then
  // simply continue into the following line's words.
  always_comb begin
    x_last    = {2'b00, cmd_q.x} + {2'b00, cmd_q.w} - 16'd1;
    wi_first  = {1'b0, cmd_q.x[13:1]};
    wi_last   = x_last[15:1];
    wi_next   = wi_q + 15'd1;
    cur_y     = {1'b0, cmd_q.y} + {1'b0, line_q};
    line_base = {17'd0, cur_y} * {18'd0, ADDRESS_DIF};
    line_more = ({1'b0, line_q} + 15'd1) < {1'b0, cmd_q.h};
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    line_d  = line_q;
    wi_d    = wi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd_in;
          line_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if ((cmd_q.w == '0) || (cmd_q.h == '0)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = line_base + {17'd0, wi_first};
          data_d  = {cmd_q.color, cmd_q.color};
          wi_d    = wi_first;
          mask_d  = word_mask(wi_first, cmd_q.x, x_last);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.ram_ack) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!mem.ram_ack) begin
          if (wi_q != wi_last) begin
            wi_d    = wi_next;
            addr_d  = addr_q + 32'd1;
            mask_d  = word_mask(wi_next, cmd_q.x, x_last);
            state_d = S_REQ;
          end else if (line_more) begin
            line_d  = line_q + 14'd1;
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      line_q      <= '0;
      wi_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      line_q      <= line_d;
      wi_q        <= wi_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign mem.fb_wen    = (state_q == S_REQ);
  assign mem.fb_addr   = addr_q;
  assign mem.fb_data   = data_q;
  assign mem.fb_mask   = mask_q;
  assign busy          = (state_q != S_IDLE);
  assign fill_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: randomized and directed fills against a per-pixel framebuffer model.
module tb_fb_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, fill_done;
  always #5 clk = ~clk;

  fb_cmd_if cif();
  fb_mem_if mif();

  fb_writer dut (
    .sdram_clk (clk),
    .reset     (reset),
    .cmd       (cif.slave),
    .mem       (mif.master),
    .busy      (busy),
    .fill_done (fill_done)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  req_cyc[$];
  int  ack_delay = 0;
  int  ack_hold  = 1;
  int  stab_err  = 0;
  int  rs = 0, rcnt = 0;
  int  last_drop_cyc = 0;
  int  done_cnt = 0, done_cyc = 0;
  int  acc_cyc = 0;
  wr_t cur_wr;

  // SDRAM arbiter stand-in: ack after ack_delay cycles, hold ack for ack_hold cycles.
  always @(negedge clk) begin
    if (reset) begin
      mif.ram_ack = 1'b0;
      rs = 0;
    end else begin
      case (rs)
        0: if (mif.fb_wen === 1'b1) begin
          cur_wr = {mif.fb_addr, mif.fb_data, mif.fb_mask};
          req_cyc.push_back(cyc);
          rcnt = 0;
          if (ack_delay == 0) begin
            mif.ram_ack = 1'b1; obs_q.push_back(cur_wr); rs = 2;
          end else rs = 1;
        end
        1: begin
          if (mif.fb_wen !== 1'b1 || {mif.fb_addr, mif.fb_data, mif.fb_mask} !== cur_wr) stab_err++;
          rcnt++;
          if (rcnt >= ack_delay) begin
            mif.ram_ack = 1'b1; obs_q.push_back(cur_wr); rs = 2; rcnt = 0;
          end
        end
        default: begin
          if (mif.fb_wen !== 1'b0) stab_err++;
          rcnt++;
          if (rcnt >= ack_hold) begin
            mif.ram_ack = 1'b0; last_drop_cyc = cyc; rs = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) if (fill_done === 1'b1) begin done_cnt++; done_cyc = cyc; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Reference: walk every pixel of the rectangle, merge pixels sharing a word.
  function automatic void build_exp(input int x, input int y, input int w, input int h, input logic [15:0] c);
    wr_t e;
    int  word;
    logic [3:0] m;
    exp_q.delete();
`ifdef FB_WRITER_CLIP_EN
    if (x >= 800) w = 0; else if (x + w > 800) w = 800 - x;
    if (y >= 480) h = 0; else if (y + h > 480) h = 480 - y;
`endif
    for (int r = 0; r < h; r++) begin
      for (int col = x; col < x + w; col++) begin
        word = (y + r) * 400 + col / 2;
        m = (col % 2 == 0) ? 4'b1100 : 4'b0011;
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].addr == 32'(word)) begin
          e = exp_q.pop_back();
          e.mask = e.mask | m;
        end else begin
          e = {32'(word), {c, c}, m};
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic issue(input int x, input int y, input int w, input int h, input logic [15:0] c);
    int n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (cif.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL issue_ready: cmd_ready=%b required 1", cif.cmd_ready);
    end
    cif.cmd_x = 14'(x); cif.cmd_y = 14'(y); cif.cmd_w = 14'(w); cif.cmd_h = 14'(h);
    cif.cmd_color = c;
    cif.cmd_valid = 1'b1;
    acc_cyc = cyc;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input logic [15:0] c);
    int n = 0;
    obs_q.delete(); req_cyc.delete();
    done_cnt = 0; stab_err = 0;
    build_exp(x, y, w, h, c);
    issue(x, y, w, h, c);
    while (done_cnt == 0 && n < 4000) begin tick(); n++; end
    checks++;
    if (done_cnt == 0) begin
      fails++; $display("FAIL done_timeout: fill_done not seen within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    cif.cmd_valid = 1'b0; cif.cmd_x = '0; cif.cmd_y = '0; cif.cmd_w = '0; cif.cmd_h = '0; cif.cmd_color = '0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cif.cmd_ready, mif.fb_wen, busy, fill_done} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: ready/wen/busy/done=%b required 0000", {cif.cmd_ready, mif.fb_wen, busy, fill_done});
    end
    checks++;
    if ({mif.fb_addr, mif.fb_data, mif.fb_mask} !== 68'd0) begin
      fails++; $display("FAIL reset_bus: addr=%h data=%h mask=%b required 0", mif.fb_addr, mif.fb_data, mif.fb_mask);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: ready=%b busy=%b required 1 0", cif.cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    ack_delay = 1; ack_hold = 1;
    run_cmd(0, 0, 4, 1, 16'hF800);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (req_cyc.size() > 0 && req_cyc[0] != acc_cyc + 2) begin
      fails++; $display("FAIL basic_latency: first fb_wen cycle %0d required %0d", req_cyc[0], acc_cyc + 2);
    end
    checks++;
    if (done_cyc != last_drop_cyc + 1) begin
      fails++; $display("FAIL basic_done_time: fill_done cycle %0d required %0d", done_cyc, last_drop_cyc + 1);
    end
    tick();
    checks++;
    if (cif.cmd_ready !== 1'b1 || done_cnt != 1) begin
      fails++; $display("FAIL basic_after: ready=%b pulses=%0d required 1 1", cif.cmd_ready, done_cnt);
    end
  endtask

  task automatic test_partial();
    ack_delay = 0; ack_hold = 1;
    run_cmd(3, 2, 2, 1, 16'h07E0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL partial_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL partial_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_multi_line();
    ack_delay = 0; ack_hold = 1;
    run_cmd(10, 5, 2, 3, 16'h001F);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL lines_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL lines_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 1; i < req_cyc.size(); i++) begin
      checks++;
      if (req_cyc[i] - req_cyc[i-1] != 3) begin
        fails++; $display("FAIL lines_gap[%0d]: request spacing %0d required 3", i, req_cyc[i] - req_cyc[i-1]);
      end
    end
  endtask

  task automatic test_zero();
    ack_delay = 0; ack_hold = 1;
    run_cmd(5, 5, 0, 4, 16'hFFFF);
    checks++;
    if (obs_q.size() != 0 || done_cyc != acc_cyc + 2) begin
      fails++; $display("FAIL zero_fill: writes=%0d done cycle %0d required 0 and %0d", obs_q.size(), done_cyc, acc_cyc + 2);
    end
    tick();
    checks++;
    if (cif.cmd_ready !== 1'b1 || cyc != done_cyc + 1) begin
      fails++; $display("FAIL zero_ready: ready=%b at cycle %0d required 1 at %0d", cif.cmd_ready, cyc, done_cyc + 1);
    end
  endtask

  task automatic test_edge();
    ack_delay = 0; ack_hold = 1;
    run_cmd(798, 0, 10, 1, 16'h1234);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL edge_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL edge_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
`ifdef FB_WRITER_CLIP_EN
    run_cmd(0, 480, 4, 2, 16'h1234);
    checks++;
    if (obs_q.size() != 0 || done_cyc != acc_cyc + 2) begin
      fails++; $display("FAIL edge_bottom: writes=%0d done cycle %0d required 0 and %0d", obs_q.size(), done_cyc, acc_cyc + 2);
    end
`endif
  endtask

  task automatic test_stall();
    ack_delay = 5; ack_hold = 3;
    run_cmd(1, 7, 5, 1, 16'hABCD);
    checks++;
    if (stab_err != 0) begin
      fails++; $display("FAIL stall_stability: %0d unstable or early-request cycles, required 0", stab_err);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stall_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    ack_delay = 0; ack_hold = 1;
    for (int k = 0; k < 2; k++) begin
      run_cmd(0, 10 + k, 8, 1, 16'h5A5A);
      checks++;
      if (req_cyc.size() != 4 || req_cyc[0] != acc_cyc + 2) begin
        fails++; $display("FAIL b2b_start[%0d]: %0d requests, first at %0d, required 4 at %0d", k, req_cyc.size(), (req_cyc.size() > 0) ? req_cyc[0] : -1, acc_cyc + 2);
      end
      for (int i = 1; i < req_cyc.size(); i++) begin
        checks++;
        if (req_cyc[i] - req_cyc[i-1] != 2) begin
          fails++; $display("FAIL b2b_gap[%0d]: request spacing %0d required 2", i, req_cyc[i] - req_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int x, y, w, h;
    logic [15:0] c;
    for (int k = 0; k < 12; k++) begin
      x = $urandom_range(0, 805); y = $urandom_range(0, 482);
      w = $urandom_range(0, 12);  h = $urandom_range(0, 3);
      c = 16'($urandom);
      ack_delay = $urandom_range(0, 3); ack_hold = $urandom_range(1, 2);
      run_cmd(x, y, w, h, c);
      checks++;
      if (obs_q.size() != exp_q.size() || stab_err != 0) begin
        fails++; $display("FAIL rand[%0d]_count: got %0d writes (%0d unstable) required %0d, x=%0d y=%0d w=%0d h=%0d", k, obs_q.size(), stab_err, exp_q.size(), x, y, w, h);
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand[%0d]_write[%0d]: got %h required %h", k, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int wen_seen = 0;
    ack_delay = 2; ack_hold = 1;
    obs_q.delete(); req_cyc.delete(); done_cnt = 0;
    issue(0, 20, 100, 2, 16'hC0DE);
    while (obs_q.size() < 2 && n < 200) begin tick(); n++; end
    reset = 1'b1;
    tick();
    checks++;
    if ({mif.fb_wen, busy, fill_done, cif.cmd_ready} !== 4'b0000 || {mif.fb_addr, mif.fb_data, mif.fb_mask} !== 68'd0) begin
      fails++; $display("FAIL midreset_outputs: wen=%b busy=%b done=%b ready=%b addr=%h data=%h mask=%b required all 0",
                        mif.fb_wen, busy, fill_done, cif.cmd_ready, mif.fb_addr, mif.fb_data, mif.fb_mask);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_release: ready=%b busy=%b required 1 0", cif.cmd_ready, busy);
    end
    for (int i = 0; i < 10; i++) begin
      if (mif.fb_wen !== 1'b0 || fill_done !== 1'b0) wen_seen++;
      tick();
    end
    checks++;
    if (wen_seen != 0) begin
      fails++; $display("FAIL midreset_abandon: %0d cycles with activity after reset, required 0", wen_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_multi_line();
    test_zero();
    test_edge();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
